mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit.sv | 192 +++++++++++++++++++
 tb/tb_mult_div_unit.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//   Iterative signed 32x32 multiplier / 32/32 divider with a fixed latency.
//   A start accepted in IDLE latches operand magnitudes and result signs. CALC
//   then runs 32 shift-add (multiply) or restoring shift-subtract (divide)
//   steps, one per clock. FIX applies sign correction, loads hi/lo and pulses
//   done. A divide by zero is resolved at the accepting edge: the sticky
//   div_zero flag is set, done pulses, and hi/lo are left untouched.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous reset, active low (0 = reset)
//   start_mult in   request signed a*b (sampled in IDLE, wins over start_div)
//   start_div  in   request signed a/b (sampled in IDLE)
//   a, b       in   32-bit two's complement operands, latched on accept
//   hi, lo     out  mult: {hi,lo} = 64-bit product; div: lo = quotient,
//                   hi = remainder (sign of dividend)
//   busy       out  high while in CALC or FIX
//   done       out  one-cycle completion pulse
//   div_zero   out  sticky divide-by-zero flag, cleared by the next valid start
// -----------------------------------------------------------------------------
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [4:0]  cnt;       // iteration counter, 0..31 during CALC
  logic [63:0] acc;       // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [31:0] opnd;      // mult: |a| (multiplicand); div: |b| (divisor)
  logic        op_div;    // operation in flight is a divide
  logic        neg_q;     // product / quotient must be negated
  logic        neg_r;     // remainder must be negated (dividend was negative)

  // ---------------------------------------------------------------------------
  // Accept decode. Multiply has priority; a divide by zero never leaves IDLE.
  // ---------------------------------------------------------------------------
  logic        in_idle;
  logic        accept_mult;
  logic        accept_div;
  logic        div_by_zero;
  logic [31:0] abs_a;
  logic [31:0] abs_b;

  assign in_idle     = (state == IDLE);
  assign accept_mult = in_idle && start_mult;
  assign accept_div  = in_idle && !start_mult && start_div && (b != 32'd0);
  assign div_by_zero = in_idle && !start_mult && start_div && (b == 32'd0);

  // |0x80000000| wraps to 0x80000000, which is the correct unsigned magnitude.
  assign abs_a = a[31] ? -a : a;
  assign abs_b = b[31] ? -b : b;

  // ---------------------------------------------------------------------------
  // One multiply step: conditionally add the multiplicand into the upper half,
  // then shift the whole accumulator right. The 33-bit sum keeps the carry,
  // which becomes bit 63 after the shift.
  // ---------------------------------------------------------------------------
  logic [32:0] mult_sum;
  logic [63:0] mult_nxt;

  assign mult_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
  assign mult_nxt = {mult_sum, acc[31:1]};

  // ---------------------------------------------------------------------------
  // One restoring divide step: shift the next dividend bit into the remainder,
  // subtract the divisor if it fits, and shift the outcome into the quotient.
  // The remainder is always below the divisor (<= 2^31), so bit 63 of acc is
  // zero here and the shifted remainder fits in 32 bits.
  // ---------------------------------------------------------------------------
  logic [31:0] rem_sh;
  logic        rem_ge;
  logic [63:0] div_nxt;

  assign rem_sh  = acc[62:31];
  assign rem_ge  = (rem_sh >= opnd);
  assign div_nxt = rem_ge ? {rem_sh - opnd, acc[30:0], 1'b1}
                          : {rem_sh,        acc[30:0], 1'b0};

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX.
  // ---------------------------------------------------------------------------
  logic [63:0] prod_fix;
  logic [31:0] quot_fix;
  logic [31:0] rem_fix;

  assign prod_fix = neg_q ? -acc : acc;
  assign quot_fix = neg_q ? -acc[31:0]  : acc[31:0];
  assign rem_fix  = neg_r ? -acc[63:32] : acc[63:32];

  // ---------------------------------------------------------------------------
  // FSM: state register and next-state logic.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: default assigned before the case so no path leaves state_nxt unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_mult || accept_div) state_nxt = CALC;
      CALC:    if (cnt == 5'd31)              state_nxt = FIX;
      FIX:                                    state_nxt = IDLE;
      default:                                state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // ---------------------------------------------------------------------------
  // Datapath and result registers.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt      <= 5'd0;
      acc      <= 64'd0;
      opnd     <= 32'd0;
      op_div   <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_mult) begin
            cnt      <= 5'd0;
            acc      <= {32'd0, abs_b};
            opnd     <= abs_a;
            op_div   <= 1'b0;
            neg_q    <= a[31] ^ b[31];
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
          end else if (accept_div) begin
            cnt      <= 5'd0;
            acc      <= {32'd0, abs_a};
            opnd     <= abs_b;
            op_div   <= 1'b1;
            neg_q    <= a[31] ^ b[31];
            neg_r    <= a[31];
            div_zero <= 1'b0;
          end else if (div_by_zero) begin
            div_zero <= 1'b1;
            done     <= 1'b1;
          end
        end
        CALC: begin
          acc <= op_div ? div_nxt : mult_nxt;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quot_fix;
          end else begin
            hi <= prod_fix[63:32];
            lo <= prod_fix[31:0];
          end
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
//   Directed bench for mult_div_unit. A transaction-level model tracks what the
//   outputs must be (result computed with plain 64-bit arithmetic, released
//   33 cycles after accept) and is compared against the DUT on every falling
//   edge. Directed vectors additionally pin hand-computed literal results,
//   latency, busy width and the divide-by-zero / reset behaviour.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_mult = 1'b0;
  logic        start_div = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int vectors = 0;
  int miscompares = 0;
  bit armed = 1'b0;

  mult_div_unit dut (
    .clk        (clk),
    .reset      (reset),
    .start_mult (start_mult),
    .start_div  (start_div),
    .a          (a),
    .b          (b),
    .hi         (hi),
    .lo         (lo),
    .busy       (busy),
    .done       (done),
    .div_zero   (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return p;
  endfunction

  // returns {remainder, quotient}
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  int          m_left;
  logic [63:0] m_pend;
  logic [31:0] m_hi, m_lo;
  logic        m_done, m_dz;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left <= 0;
      m_pend <= 64'd0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      m_done <= 1'b0;
      m_dz   <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end else if (start_mult) begin
        m_pend <= ref_mul(a, b);
        m_left <= 33;
        m_dz   <= 1'b0;
      end else if (start_div) begin
        if (b == 32'd0) begin
          m_dz   <= 1'b1;
          m_done <= 1'b1;
        end else begin
          m_pend <= ref_div(a, b);
          m_left <= 33;
          m_dz   <= 1'b0;
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("busy",     {63'd0, busy},     {63'd0, (m_left > 0)});
      check("done",     {63'd0, done},     {63'd0, m_done});
      check("div_zero", {63'd0, div_zero}, {63'd0, m_dz});
      check("hi",       {32'd0, hi},       {32'd0, m_hi});
      check("lo",       {32'd0, lo},       {32'd0, m_lo});
    end
  end

  // ---------------------------------------------------------------------------
  // Issue one operation and observe a fixed 40-cycle window. Index i counts
  // falling edges after the accepting edge. inj >= 0 pulses start_div (b=0)
  // for one cycle at that index, which must be ignored while busy.
  // ---------------------------------------------------------------------------
  task automatic do_op(input logic sm, input logic sd, input logic [31:0] aa, input logic [31:0] bb,
                       input int inj, output int busy_n, output int done_n, output int done_at);
    @(negedge clk);
    start_mult = sm;
    start_div  = sd;
    a = aa;
    b = bb;
    busy_n  = 0;
    done_n  = 0;
    done_at = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) begin
        start_mult = 1'b0;
        start_div  = 1'b0;
        a = $urandom;
        b = $urandom;
      end
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        if (done_at < 0) done_at = i;
      end
      if (i == inj) begin
        start_div = 1'b1;
        a = 32'd9;
        b = 32'd0;
      end else if (i == inj + 1) begin
        start_div = 1'b0;
      end
    end
  endtask

  int bn, dn, dat;
  int d1, d2, dcount;
  bit busy_after;

  initial begin
    // Reset
    #2 reset = 1'b0;
    armed = 1'b1;
    #1;
    check("rst_hi",   {32'd0, hi}, 64'd0);
    check("rst_lo",   {32'd0, lo}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_dz",   {63'd0, div_zero}, 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // 7 * -3 = -21
    do_op(1'b1, 1'b0, 32'd7, 32'hFFFFFFFD, -1, bn, dn, dat);
    check("mul1_busy_cycles", 64'(bn), 64'd33);
    check("mul1_done_pulses", 64'(dn), 64'd1);
    check("mul1_latency",     64'(dat), 64'd33);
    check("mul1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);

    // -7 / 2 -> q=-3, r=-1
    do_op(1'b0, 1'b1, 32'hFFFFFFF9, 32'd2, -1, bn, dn, dat);
    check("div1_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
    check("div1_dz",   {63'd0, div_zero}, 64'd0);

    // 5 / 0 -> flag, immediate done, results held
    do_op(1'b0, 1'b1, 32'd5, 32'd0, -1, bn, dn, dat);
    check("dz_done_at",     64'(dat), 64'd0);
    check("dz_done_pulses", 64'(dn), 64'd1);
    check("dz_busy_cycles", 64'(bn), 64'd0);
    check("dz_flag",        {63'd0, div_zero}, 64'd1);
    check("dz_hilo_held",   {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // Most negative squared; also clears div_zero
    do_op(1'b1, 1'b0, 32'h80000000, 32'h80000000, -1, bn, dn, dat);
    check("mul_minsq_hilo", {hi, lo}, 64'h40000000_00000000);
    check("mul_dz_cleared", {63'd0, div_zero}, 64'd0);

    // start_div (b=0) during CALC of a mult must be ignored
    do_op(1'b1, 1'b0, 32'd1000, 32'hFFFFFC18, 5, bn, dn, dat);
    check("inj_hilo", {hi, lo}, 64'hFFFFFFFF_FFF0BDC0);
    check("inj_dz",   {63'd0, div_zero}, 64'd0);

    // Both starts high: multiply wins (-5*6 = -30)
    do_op(1'b1, 1'b1, 32'hFFFFFFFB, 32'd6, -1, bn, dn, dat);
    check("both_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFE2);

    // 100 / -7 -> q=-14, r=2
    do_op(1'b0, 1'b1, 32'd100, 32'hFFFFFFF9, -1, bn, dn, dat);
    check("div2_hilo", {hi, lo}, 64'h00000002_FFFFFFF2);

    // Asynchronous reset at CALC iteration 10
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'h12345;
    b = 32'h777;
    @(posedge clk);
    #1 start_mult = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("arst_hi",   {32'd0, hi}, 64'd0);
    check("arst_lo",   {32'd0, lo}, 64'd0);
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) dcount++;
      if (i == 2) reset = 1'b1;
    end
    check("arst_no_done", 64'(dcount), 64'd0);

    // Most negative / -1 right after reset
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, -1, bn, dn, dat);
    check("div_ovf_latency", 64'(dat), 64'd33);
    check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);
    check("div_ovf_dz",   {63'd0, div_zero}, 64'd0);

    // Back-to-back multiplies with start held high
    @(negedge clk);
    start_mult = 1'b1;
    a = 32'd3;
    b = 32'd4;
    d1 = -1;
    d2 = -1;
    busy_after = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (d1 >= 0 && i == d1 + 1) busy_after = busy;
      if (done) begin
        if (d1 < 0) d1 = i;
        else if (d2 < 0) d2 = i;
      end
    end
    start_mult = 1'b0;
    check("b2b_first_done",  64'(d1), 64'd33);
    check("b2b_spacing",     64'(d2 - d1), 64'd34);
    check("b2b_reaccept",    {63'd0, busy_after}, 64'd1);
    repeat (40) @(negedge clk);
    check("b2b_hilo", {hi, lo}, 64'd12);

    // A few more operations checked by the model only
    for (int n = 0; n < 4; n++) begin
      do_op(n[0] ? 1'b0 : 1'b1, n[0], $urandom, $urandom | 32'd1, -1, bn, dn, dat);
    end
    do_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, -1, bn, dn, dat);
    check("mul_m1sq_hilo", {hi, lo}, 64'd1);
    do_op(1'b0, 1'b1, 32'd7, 32'd100, -1, bn, dn, dat);
    check("div_small_hilo", {hi, lo}, 64'h00000007_00000000);

    @(negedge clk);
    armed = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
